// File: rtl/frog_motion_ctrl.sv
// Frame-rate frog position controller: WASD hops, log riding, drowning, home arrival and score.
// All state advances on a one-Clk tick derived from the rising edge of the asynchronous frame_clk.
module frog_motion_ctrl #(
    parameter int START_X      = 308,
    parameter int START_Y      = 456,
    parameter int STEP_X       = 24,
    parameter int STEP_Y       = 22,
    parameter int FROG_W       = 24,
    parameter int FROG_H       = 22,
    parameter int MAX_X        = 615,
    parameter int WATER_TOP    = 37,
    parameter int WATER_BOT    = 225,
    parameter int HOME_Y       = 36,
    parameter int LOG_Y        = 100,
    parameter int COOLDOWN     = 8,
    parameter int DEATH_FRAMES = 60
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [10:0] Log1_X,
    output logic [10:0] Frog_X,
    output logic [10:0] Frog_Y,
    output logic        Frog_dead,
    output logic [3:0]  Score,
    output logic [1:0]  o_dbg_state
);
    typedef enum logic [1:0] {
        S_READY    = 2'd0,
        S_COOLDOWN = 2'd1,
        S_DEAD     = 2'd2
    } state_t;

    localparam int CNT_MAX = (DEATH_FRAMES > COOLDOWN) ? DEATH_FRAMES : COOLDOWN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [11:0] C_START_X   = 12'(START_X);
    localparam logic [11:0] C_START_Y   = 12'(START_Y);
    localparam logic [11:0] C_STEP_X    = 12'(STEP_X);
    localparam logic [11:0] C_STEP_Y    = 12'(STEP_Y);
    localparam logic [11:0] C_HALF_W    = 12'(FROG_W / 2);
    localparam logic [11:0] C_LOG_LEN   = 12'(2 * FROG_W - 1);
    localparam logic [11:0] C_FROG_H    = 12'(FROG_H);
    localparam logic [11:0] C_MAX_X     = 12'(MAX_X);
    localparam logic [11:0] C_WATER_TOP = 12'(WATER_TOP);
    localparam logic [11:0] C_WATER_BOT = 12'(WATER_BOT);
    localparam logic [11:0] C_HOME_Y    = 12'(HOME_Y);
    localparam logic [11:0] C_LOG_Y     = 12'(LOG_Y);

    state_t             r_state, w_nxt_state;
    logic               r_fc_meta, r_fc_sync, r_fc_prev;
    logic [10:0]        r_x, r_y, r_prev_log;
    logic [3:0]         r_score;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_key_armed, r_dead;

    logic [10:0]        w_nxt_x, w_nxt_y, w_hop_x, w_hop_y, w_base_x;
    logic [3:0]         w_nxt_score;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_nxt_armed;

    logic               w_tick;
    logic [11:0]        w_x12, w_y12, w_log12, w_base12, w_center;
    logic               w_riding, w_home, w_drown, w_ride_oob;
    logic signed [10:0] w_raw_dx;
    logic signed [11:0] w_ride_dx, w_ride_x;
    logic               w_key_w, w_key_a, w_key_s, w_key_d, w_key_valid;

    assign w_tick = r_fc_sync & ~r_fc_prev;

    assign w_x12    = {1'b0, r_x};
    assign w_y12    = {1'b0, r_y};
    assign w_log12  = {1'b0, Log1_X};
    assign w_center = w_x12 + C_HALF_W;

    assign w_riding = (w_y12 >= C_LOG_Y) && (w_y12 <= C_LOG_Y + C_FROG_H) &&
                      (w_center >= w_log12) && (w_center <= w_log12 + C_LOG_LEN);
    assign w_home   = (w_y12 <= C_HOME_Y);
    assign w_drown  = (w_y12 + C_FROG_H - 12'd1 >= C_WATER_TOP) && (w_y12 <= C_WATER_BOT) && !w_riding;

    // A log step larger than 8 px means the mover wrapped the log around the screen.
    assign w_raw_dx   = $signed(Log1_X - r_prev_log);
    assign w_ride_dx  = ((w_raw_dx > 11'sd8) || (w_raw_dx < -11'sd8)) ? 12'sd0 : {w_raw_dx[10], w_raw_dx};
    assign w_ride_x   = $signed(w_x12) + w_ride_dx;
    assign w_ride_oob = (w_ride_x < 12'sd0) || (w_ride_x > $signed(C_MAX_X));

    assign w_key_w     = (keycode == 8'h1A);
    assign w_key_a     = (keycode == 8'h04);
    assign w_key_s     = (keycode == 8'h16);
    assign w_key_d     = (keycode == 8'h07);
    assign w_key_valid = w_key_w | w_key_a | w_key_s | w_key_d;

    // Hops start from the post-ride position.
    assign w_base_x = w_riding ? w_ride_x[10:0] : r_x;
    assign w_base12 = {1'b0, w_base_x};

    always_comb begin
        w_hop_x = w_base_x;
        w_hop_y = r_y;
        if (w_key_a) begin
            w_hop_x = (w_base12 < C_STEP_X) ? 11'd0 : 11'(w_base12 - C_STEP_X);
        end else if (w_key_d) begin
            w_hop_x = (w_base12 + C_STEP_X > C_MAX_X) ? C_MAX_X[10:0] : 11'(w_base12 + C_STEP_X);
        end
        if (w_key_w) begin
            w_hop_y = (w_y12 < C_STEP_Y) ? 11'd0 : 11'(w_y12 - C_STEP_Y);
        end else if (w_key_s) begin
            w_hop_y = (w_y12 + C_STEP_Y > C_START_Y) ? C_START_Y[10:0] : 11'(w_y12 + C_STEP_Y);
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_x     = r_x;
        w_nxt_y     = r_y;
        w_nxt_score = r_score;
        w_nxt_cnt   = r_cnt;
        w_nxt_armed = r_key_armed;
        if (w_tick) begin
            if (!w_key_valid) w_nxt_armed = 1'b1;
            if (r_state == S_DEAD) begin
                if (r_cnt <= CNT_ONE) begin
                    w_nxt_state = S_READY;
                    w_nxt_x     = C_START_X[10:0];
                    w_nxt_y     = C_START_Y[10:0];
                    w_nxt_cnt   = '0;
                    w_nxt_armed = 1'b0;
                end else begin
                    w_nxt_cnt = r_cnt - CNT_ONE;
                end
            end else begin
                if (r_state == S_COOLDOWN) begin
                    if (r_cnt <= CNT_ONE) begin
                        w_nxt_state = S_READY;
                        w_nxt_cnt   = '0;
                    end else begin
                        w_nxt_cnt = r_cnt - CNT_ONE;
                    end
                end
                if (w_home) begin
                    w_nxt_score = (r_score >= 4'd9) ? 4'd9 : r_score + 4'd1;
                    w_nxt_x     = C_START_X[10:0];
                    w_nxt_y     = C_START_Y[10:0];
                    w_nxt_state = S_READY;
                    w_nxt_cnt   = '0;
                end else if (w_drown || (w_riding && w_ride_oob)) begin
                    w_nxt_state = S_DEAD;
                    w_nxt_cnt   = CNT_W'(DEATH_FRAMES);
                end else begin
                    if (w_riding) w_nxt_x = w_ride_x[10:0];
                    if ((r_state == S_READY) && r_key_armed && w_key_valid) begin
                        w_nxt_x     = w_hop_x;
                        w_nxt_y     = w_hop_y;
                        w_nxt_armed = 1'b0;
                        w_nxt_state = S_COOLDOWN;
                        w_nxt_cnt   = CNT_W'(COOLDOWN);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fc_meta   <= 1'b0;
            r_fc_sync   <= 1'b0;
            r_fc_prev   <= 1'b0;
            r_state     <= S_READY;
            r_x         <= C_START_X[10:0];
            r_y         <= C_START_Y[10:0];
            r_score     <= 4'd0;
            r_cnt       <= '0;
            r_key_armed <= 1'b1;
            r_dead      <= 1'b0;
            r_prev_log  <= 11'd0;
        end else begin
            r_fc_meta   <= frame_clk;
            r_fc_sync   <= r_fc_meta;
            r_fc_prev   <= r_fc_sync;
            r_state     <= w_nxt_state;
            r_x         <= w_nxt_x;
            r_y         <= w_nxt_y;
            r_score     <= w_nxt_score;
            r_cnt       <= w_nxt_cnt;
            r_key_armed <= w_nxt_armed;
            r_dead      <= (w_nxt_state == S_DEAD);
            if (w_tick) r_prev_log <= Log1_X;
        end
    end

    assign Frog_X      = r_x;
    assign Frog_Y      = r_y;
    assign Frog_dead   = r_dead;
    assign Score       = r_score;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_frog_motion_ctrl.sv
// Directed bench: main instance for hops/drowning, a log-row instance for riding and a home-row instance for scoring.
module tb_frog_motion_ctrl;
  localparam logic [7:0] K_W = 8'h1A;
  localparam logic [7:0] K_A = 8'h04;
  localparam logic [7:0] K_S = 8'h16;
  localparam logic [7:0] K_D = 8'h07;
  localparam logic [1:0] ST_READY = 2'd0;
  localparam logic [1:0] ST_COOL  = 2'd1;
  localparam logic [1:0] ST_DEAD  = 2'd2;

  logic clk = 1'b0;
  logic frame_clk = 1'b0;
  logic rst_main = 1'b0, rst_ride = 1'b0, rst_home = 1'b0;
  logic [7:0] kc_main = 8'h00, kc_ride = 8'h00, kc_home = 8'h00;
  logic [10:0] log_main = 11'd0, log_ride = 11'd296, log_home = 11'd0;

  logic [10:0] m_x, m_y, r_x, r_y, h_x, h_y;
  logic m_dead, r_dead, h_dead;
  logic [3:0] m_score, r_score, h_score;
  logic [1:0] m_st, r_st, h_st;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  frog_motion_ctrl u_main (
    .Clk(clk), .Reset_n(rst_main), .frame_clk(frame_clk), .keycode(kc_main), .Log1_X(log_main),
    .Frog_X(m_x), .Frog_Y(m_y), .Frog_dead(m_dead), .Score(m_score), .o_dbg_state(m_st)
  );

  frog_motion_ctrl #(.START_Y(122)) u_ride (
    .Clk(clk), .Reset_n(rst_ride), .frame_clk(frame_clk), .keycode(kc_ride), .Log1_X(log_ride),
    .Frog_X(r_x), .Frog_Y(r_y), .Frog_dead(r_dead), .Score(r_score), .o_dbg_state(r_st)
  );

  frog_motion_ctrl #(.START_Y(14)) u_home (
    .Clk(clk), .Reset_n(rst_home), .frame_clk(frame_clk), .keycode(kc_home), .Log1_X(log_home),
    .Frog_X(h_x), .Frog_Y(h_y), .Frog_dead(h_dead), .Score(h_score), .o_dbg_state(h_st)
  );

  task automatic tick();
    @(negedge clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // One accepted hop on the main instance, then release and sit out the cooldown.
  task automatic hop_main(input logic [7:0] k);
    kc_main = k;
    tick();
    kc_main = 8'h00;
    repeat (8) tick();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++; if (m_x !== 11'd308) begin fails++; $display("FAIL reset_hold_x: got %0d expected 308", m_x); end
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL reset_hold_y: got %0d expected 456", m_y); end
    rst_main = 1'b1;
    kc_main = 8'h00;
    repeat (3) tick();
    tests++; if (m_x !== 11'd308) begin fails++; $display("FAIL reset_x: got %0d expected 308", m_x); end
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL reset_y: got %0d expected 456", m_y); end
    tests++; if (m_score !== 4'd0) begin fails++; $display("FAIL reset_score: got %0d expected 0", m_score); end
    tests++; if (m_dead !== 1'b0) begin fails++; $display("FAIL reset_dead: got %0d expected 0", m_dead); end
    tests++; if (m_st !== ST_READY) begin fails++; $display("FAIL reset_state: got %0d expected %0d", m_st, ST_READY); end
  endtask

  task automatic test_hop_once();
    kc_main = K_W;
    repeat (20) @(negedge clk);
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL no_tick_no_move: got %0d expected 456", m_y); end
    tick();
    tests++; if (m_y !== 11'd434) begin fails++; $display("FAIL hop_w_y: got %0d expected 434", m_y); end
    tests++; if (m_st !== ST_COOL) begin fails++; $display("FAIL hop_w_state: got %0d expected %0d", m_st, ST_COOL); end
    repeat (20) tick();
    tests++; if (m_y !== 11'd434) begin fails++; $display("FAIL hold_w_one_hop: got %0d expected 434", m_y); end
    tests++; if (m_x !== 11'd308) begin fails++; $display("FAIL hold_w_x: got %0d expected 308", m_x); end
    kc_main = 8'h00;
    tick();
    kc_main = K_W;
    tick();
    tests++; if (m_y !== 11'd412) begin fails++; $display("FAIL second_w_y: got %0d expected 412", m_y); end
    kc_main = 8'h00;
    repeat (8) tick();
  endtask

  task automatic test_edges();
    repeat (13) hop_main(K_A);
    tests++; if (m_x !== 11'd0) begin fails++; $display("FAIL walk_left_x: got %0d expected 0", m_x); end
    kc_main = K_A;
    tick();
    tests++; if (m_x !== 11'd0) begin fails++; $display("FAIL left_clamp_x: got %0d expected 0", m_x); end
    tests++; if (m_st !== ST_COOL) begin fails++; $display("FAIL clamped_hop_state: got %0d expected %0d", m_st, ST_COOL); end
    kc_main = 8'h00;
    repeat (7) tick();
    tests++; if (m_st !== ST_COOL) begin fails++; $display("FAIL cooldown_7: got %0d expected %0d", m_st, ST_COOL); end
    tick();
    tests++; if (m_st !== ST_READY) begin fails++; $display("FAIL cooldown_8: got %0d expected %0d", m_st, ST_READY); end
    repeat (26) hop_main(K_D);
    tests++; if (m_x !== 11'd615) begin fails++; $display("FAIL right_clamp_x: got %0d expected 615", m_x); end
    repeat (3) hop_main(K_S);
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL bottom_clamp_y: got %0d expected 456", m_y); end
  endtask

  task automatic test_drown();
    repeat (10) hop_main(K_W);
    tests++; if (m_y !== 11'd236) begin fails++; $display("FAIL shore_y: got %0d expected 236", m_y); end
    kc_main = K_W;
    tick();
    tests++; if (m_y !== 11'd214) begin fails++; $display("FAIL into_water_y: got %0d expected 214", m_y); end
    tests++; if (m_dead !== 1'b0) begin fails++; $display("FAIL drown_latency: got %0d expected 0", m_dead); end
    kc_main = 8'h00;
    tick();
    tests++; if (m_dead !== 1'b1) begin fails++; $display("FAIL drown_dead: got %0d expected 1", m_dead); end
    tests++; if (m_st !== ST_DEAD) begin fails++; $display("FAIL drown_state: got %0d expected %0d", m_st, ST_DEAD); end
    tests++; if (m_y !== 11'd214) begin fails++; $display("FAIL drown_hold_y: got %0d expected 214", m_y); end
    repeat (59) tick();
    tests++; if (m_dead !== 1'b1) begin fails++; $display("FAIL dead_59: got %0d expected 1", m_dead); end
    tick();
    tests++; if (m_dead !== 1'b0) begin fails++; $display("FAIL dead_60: got %0d expected 0", m_dead); end
    tests++; if (m_x !== 11'd308) begin fails++; $display("FAIL respawn_x: got %0d expected 308", m_x); end
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL respawn_y: got %0d expected 456", m_y); end
    tests++; if (m_score !== 4'd0) begin fails++; $display("FAIL respawn_score: got %0d expected 0", m_score); end
    kc_main = K_W;
    tick();
    tests++; if (m_y !== 11'd456) begin fails++; $display("FAIL respawn_disarmed: got %0d expected 456", m_y); end
    kc_main = 8'h00;
    tick();
    kc_main = K_W;
    tick();
    tests++; if (m_y !== 11'd434) begin fails++; $display("FAIL rearmed_hop: got %0d expected 434", m_y); end
    kc_main = 8'h00;
  endtask

  task automatic test_ride();
    log_ride = 11'd296;
    rst_ride = 1'b1;
    tick();
    tests++; if (r_x !== 11'd308) begin fails++; $display("FAIL ride_first_x: got %0d expected 308", r_x); end
    tests++; if (r_dead !== 1'b0) begin fails++; $display("FAIL ride_first_dead: got %0d expected 0", r_dead); end
    log_ride = 11'd298; tick();
    tests++; if (r_x !== 11'd310) begin fails++; $display("FAIL ride_plus2: got %0d expected 310", r_x); end
    log_ride = 11'd300; tick();
    log_ride = 11'd302; tick();
    tests++; if (r_x !== 11'd314) begin fails++; $display("FAIL ride_track: got %0d expected 314", r_x); end
    log_ride = 11'd314; tick();
    tests++; if (r_x !== 11'd314) begin fails++; $display("FAIL ride_jump_plus12: got %0d expected 314", r_x); end
    log_ride = 11'd322; tick();
    tests++; if (r_x !== 11'd322) begin fails++; $display("FAIL ride_plus8: got %0d expected 322", r_x); end
    log_ride = 11'd313; tick();
    tests++; if (r_x !== 11'd322) begin fails++; $display("FAIL ride_minus9: got %0d expected 322", r_x); end
    log_ride = 11'd311; tick();
    tests++; if (r_x !== 11'd320) begin fails++; $display("FAIL ride_minus2: got %0d expected 320", r_x); end
    log_ride = 11'd1000; tick();
    tests++; if (r_dead !== 1'b1) begin fails++; $display("FAIL log_gone_dead: got %0d expected 1", r_dead); end
    tests++; if (r_x !== 11'd320) begin fails++; $display("FAIL log_gone_x: got %0d expected 320", r_x); end
  endtask

  task automatic test_reset_mid_dead();
    repeat (5) tick();
    tests++; if (r_st !== ST_DEAD) begin fails++; $display("FAIL still_dead: got %0d expected %0d", r_st, ST_DEAD); end
    @(negedge clk);
    rst_ride = 1'b0;
    #1;
    tests++; if (r_dead !== 1'b0) begin fails++; $display("FAIL async_rst_dead: got %0d expected 0", r_dead); end
    tests++; if (r_x !== 11'd308) begin fails++; $display("FAIL async_rst_x: got %0d expected 308", r_x); end
    tests++; if (r_y !== 11'd122) begin fails++; $display("FAIL async_rst_y: got %0d expected 122", r_y); end
    tests++; if (r_st !== ST_READY) begin fails++; $display("FAIL async_rst_state: got %0d expected %0d", r_st, ST_READY); end
  endtask

  task automatic test_home();
    rst_home = 1'b1;
    tick();
    tests++; if (h_score !== 4'd1) begin fails++; $display("FAIL home_score1: got %0d expected 1", h_score); end
    tests++; if (h_y !== 11'd14) begin fails++; $display("FAIL home_respawn_y: got %0d expected 14", h_y); end
    tests++; if (h_x !== 11'd308) begin fails++; $display("FAIL home_respawn_x: got %0d expected 308", h_x); end
    tests++; if (h_st !== ST_READY) begin fails++; $display("FAIL home_state: got %0d expected %0d", h_st, ST_READY); end
    repeat (8) tick();
    tests++; if (h_score !== 4'd9) begin fails++; $display("FAIL home_score9: got %0d expected 9", h_score); end
    tick();
    tests++; if (h_score !== 4'd9) begin fails++; $display("FAIL home_saturate: got %0d expected 9", h_score); end
    tests++; if (h_dead !== 1'b0) begin fails++; $display("FAIL home_dead: got %0d expected 0", h_dead); end
  endtask

  initial begin
    test_reset();
    test_hop_once();
    test_edges();
    test_drown();
    test_ride();
    test_reset_mid_dead();
    test_home();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
